wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and status controller for the parametrised async FIFO. It is the successor to the basic write-pointer block and adds the following:
- full-gated increment
- programmable almost-full margin
- write-side fill level
- sticky overflow error with clear

It drives the dual-port RAM write address and the Gray pointer sent to the read-domain synchroniser. It consumes the 2-flop-synchronised read Gray pointer.

Parameters:
ADDR_WIDTH, 6, RAM address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AF_MARGIN, 4, almost_full asserts when level >= DEPTH-AF_MARGIN; legal range 1..DEPTH-1.

Ports:
clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
inc  in  1  write request
wq2_rptr  in  ADDR_WIDTH+1  read pointer (Gray), already synchronised into clk domain
ovf_clr  in  1  clears sticky overflow
wr_accept  out  1  combinational: inc & ~full; the RAM write enable
waddr  out  ADDR_WIDTH  RAM write address = binary pointer low bits
wptr  out  ADDR_WIDTH+1  registered Gray write pointer to synchroniser
full  out  1  registered full flag
almost_full  out  1  registered almost-full flag
wlevel  out  ADDR_WIDTH+1  registered fill level 0..DEPTH
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (async, rst_n=0): wptr, binary pointer, full, almost_full, wlevel and overflow all go to 0. waddr is therefore 0. wr_accept = inc (full=0).
- Pointer advance:
  - bin_next = bin + wr_accept, modulo 2**(ADDR_WIDTH+1).
  - gray_next = (bin_next>>1) ^ bin_next.
  - Both bin and gray are registered on the same edge.
- Gating: inc while full is dropped. The pointer must not move. The write must never be enabled.
- Full:
  - full_next = (gray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}).
  - This is the standard MSB-two-inverted Gray compare. It is valid for ADDR_WIDTH >= 2.
- Level:
  - rbin = gray_to_bin(wq2_rptr).
  - level_next = bin_next - rbin, as (ADDR_WIDTH+1)-bit unsigned. Wrap is handled naturally by modulo arithmetic.
  - wlevel is registered. It is conservative: it over-reports by up to the sync latency and never under-reports.
- almost_full_next = (level_next >= DEPTH-AF_MARGIN). full implies almost_full.
- Overflow:
  - Set on the edge where inc & full.
  - Cleared on the edge where ovf_clr=1 and no new overflow is detected. Set has priority over clear in the same cycle.
  - It holds otherwise.
- Latency: all flags and wlevel reflect the write issued in the previous cycle. A write on cycle N updates full/wlevel at edge N+1.
- Read-side release: a change in wq2_rptr updates full/almost_full/wlevel on the next edge, even with no write.
- Simultaneous write and read-pointer advance at the full boundary: compute from gray_next against the current wq2_rptr. No special casing.
- Wrap-around: the pointer passes 2**(ADDR_WIDTH+1)-1 -> 0. The Gray code changes exactly one bit per increment, including at wrap.
- Reset mid-operation: everything clears immediately. The read domain must be reset concurrently; this block does not check that.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parametrised by width via a let/parameterised class or a width argument.
  - Localparam helpers FIFO_PTR_W(aw) = aw+1.
- Sub-module gray_to_bin, parametrised WIDTH, purely combinational XOR-prefix.
  - It is reused by the read-side controller for rlevel.
- The rest is one always_ff plus next-state logic, about 150-200 lines.

Test Plan:
All scenarios use ADDR_WIDTH=4 (DEPTH=16) and AF_MARGIN=2.
1. Reset, then 16 consecutive inc with wq2_rptr=0:
   - full rises at the edge after the 16th write; wptr=5'b11000, wlevel=16.
   - almost_full rises after the 14th write with wlevel=14.
   - waddr steps 0..15.
2. Full, then inc held high 3 cycles:
   - wr_accept=0 throughout; wptr stays 5'b11000.
   - overflow=1 after the first such edge and stays 1 after inc drops.
   - Then ovf_clr pulse: overflow=0 next edge.
3. Full, then wq2_rptr=gray(1)=5'b00001 with no writes:
   - full=0, almost_full=1, wlevel=15 after one edge.
   - A following inc is accepted, and full=1 again.
4. Wrap: alternately write and advance wq2_rptr for 40 writes:
   - the binary pointer passes 31->0;
   - wptr changes exactly one bit per accepted write;
   - wlevel never exceeds 16 and matches the model.
5. Same-cycle inc & full & ovf_clr:
   - overflow remains 1 (set wins);
   - wptr is unchanged.
6. Assert rst_n low mid-burst at level 9:
   - all outputs are 0 asynchronously, before the next clk edge;
   - after release, the first write goes to waddr 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width and Gray/binary conversion.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

    // Pointers carry one extra wrap bit beyond the RAM address.
    function automatic int fifo_ptr_w(input int aw);
        return aw + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Width argument masks off bits above the pointer; input bits above width must be zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
        logic [31:0] bin;
        logic [31:0] mask;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return bin & mask;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
// Shared by the write-side and read-side level calculations.
module gray_to_bin #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status controller for the async FIFO: Gray pointer, full,
// almost-full, fill level and sticky overflow, all computed from the synchronised read pointer.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  ovf_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);

    localparam int PW    = fifo_ptr_w(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] bin_p0;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rptr_full_cmp;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          almost_full_next;
    logic          overflow_next;
    logic          write_blocked;

    gray_to_bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // Stage p0 next-state: pointer advance gated by the current registered full flag.
    always_comb begin
        wr_accept     = inc & ~full;
        write_blocked = inc & full;
        bin_next      = bin_p0 + PW'(wr_accept);
        gray_next     = PW'(bin2gray(32'(bin_next)));
    end

    // Full when the write pointer has lapped the read pointer by exactly DEPTH:
    // in Gray code that is the two MSBs inverted, the rest equal.
    always_comb begin
        rptr_full_cmp = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
        full_next     = (gray_next == rptr_full_cmp);
    end

    // Modulo subtraction handles wrap; the stale read pointer makes this over-report only.
    always_comb begin
        level_next       = bin_next - rbin;
        almost_full_next = (level_next >= AF_THRESH);
    end

    // A new overflow wins over a clear in the same cycle.
    always_comb begin
        overflow_next = write_blocked | (overflow & ~ovf_clr);
    end

    // Stage p0 registers: everything is reset so no output is ever undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_p0      <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            bin_p0      <= bin_next;
            wptr        <= gray_next;
            full        <= full_next;
            almost_full <= almost_full_next;
            wlevel      <= level_next;
            overflow    <= overflow_next;
        end
    end

    assign waddr = bin_p0[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ADDR_WIDTH=4, AF_MARGIN=2.
module tb_wptr_full_ctrl;

    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          inc;
    logic [AW:0]   wq2_rptr;
    logic          ovf_clr;
    logic          wr_accept;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wlevel;
    logic          overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    wptr_full_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_MARGIN  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (inc),
        .wq2_rptr    (wq2_rptr),
        .ovf_clr     (ovf_clr),
        .wr_accept   (wr_accept),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW:0] g5(input logic [AW:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inc      = 1'b0;
        ovf_clr  = 1'b0;
        wq2_rptr = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({wptr, full, almost_full, wlevel, overflow, waddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got wptr=%b full=%b af=%b lvl=%0d ovf=%b waddr=%0d required all 0",
                     wptr, full, almost_full, wlevel, overflow, waddr);
        end
        inc = 1'b1;
        #1;
        n_cmp++;
        if (wr_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_accept: got %b required 1", wr_accept);
        end
        inc = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            inc = 1'b1;
            #1;
            n_cmp++;
            if (waddr !== AW'(i) || wr_accept !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_waddr[%0d]: got waddr=%0d accept=%b required %0d/1", i, waddr, wr_accept, i);
            end
            step();
            n_cmp++;
            if (wlevel !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16)) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: got lvl=%0d af=%b full=%b required %0d/%b/%b",
                         i, wlevel, almost_full, full, i + 1, (i + 1 >= 14), (i + 1 == 16));
            end
        end
        inc = 1'b0;
        n_cmp++;
        if (wptr !== 5'b11000) begin
            n_fail++;
            $display("FAIL fill_wptr: got %b required 11000", wptr);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            inc = 1'b1;
            #1;
            n_cmp++;
            if (wr_accept !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_accept[%0d]: got %b required 0", i, wr_accept);
            end
            step();
            n_cmp++;
            if (overflow !== 1'b1 || wptr !== 5'b11000 || full !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_set[%0d]: got ovf=%b wptr=%b full=%b required 1/11000/1", i, overflow, wptr, full);
            end
        end
        inc = 1'b0;
        step();
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: got %b required 1", overflow);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b required 0", overflow);
        end
    endtask

    task automatic test_release();
        wq2_rptr = 5'b00001;
        step();
        n_cmp++;
        if (full !== 1'b0 || almost_full !== 1'b1 || wlevel !== 5'd15) begin
            n_fail++;
            $display("FAIL release: got full=%b af=%b lvl=%0d required 0/1/15", full, almost_full, wlevel);
        end
        inc = 1'b1;
        #1;
        n_cmp++;
        if (wr_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL release_accept: got %b required 1", wr_accept);
        end
        step();
        inc = 1'b0;
        n_cmp++;
        if (full !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11001) begin
            n_fail++;
            $display("FAIL refill: got full=%b lvl=%0d wptr=%b required 1/16/11001", full, wlevel, wptr);
        end
    endtask

    task automatic test_same_cycle();
        inc = 1'b1;
        step();
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL same_setup: got ovf=%b required 1", overflow);
        end
        ovf_clr = 1'b1;
        step();
        inc     = 1'b0;
        ovf_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || wptr !== 5'b11001) begin
            n_fail++;
            $display("FAIL set_wins: got ovf=%b wptr=%b required 1/11001", overflow, wptr);
        end
    endtask

    task automatic test_wrap();
        logic [AW:0] wb;
        logic [AW:0] rb;
        logic [AW:0] prev;
        do_reset();
        wb   = '0;
        rb   = '0;
        prev = wptr;
        for (int i = 0; i < 40; i++) begin
            inc = 1'b1;
            step();
            inc = 1'b0;
            wb  = wb + 1'b1;
            n_cmp++;
            if (wptr !== g5(wb) || $countones(wptr ^ prev) != 1 || wlevel !== 5'(wb - rb) || wlevel > 5'd16) begin
                n_fail++;
                $display("FAIL wrap_write[%0d]: got wptr=%b prev=%b lvl=%0d required wptr=%b lvl=%0d",
                         i, wptr, prev, wlevel, g5(wb), 5'(wb - rb));
            end
            prev     = wptr;
            rb       = rb + 1'b1;
            wq2_rptr = g5(rb);
            step();
            n_cmp++;
            if (wlevel !== 5'(wb - rb) || full !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_read[%0d]: got lvl=%0d full=%b required %0d/0", i, wlevel, full, 5'(wb - rb));
            end
        end
        n_cmp++;
        if (waddr !== 4'd8 || wptr !== 5'b01100) begin
            n_fail++;
            $display("FAIL wrap_end: got waddr=%0d wptr=%b required 8/01100", waddr, wptr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inc = 1'b1;
        repeat (9) step();
        n_cmp++;
        if (wlevel !== 5'd9 || waddr !== 4'd9) begin
            n_fail++;
            $display("FAIL mid_level: got lvl=%0d waddr=%0d required 9/9", wlevel, waddr);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wptr, full, almost_full, wlevel, overflow, waddr} !== '0 || wr_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_async_reset: got wptr=%b lvl=%0d waddr=%0d accept=%b required 0/0/0/1",
                     wptr, wlevel, waddr, wr_accept);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (waddr !== 4'd0 || wr_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_addr: got waddr=%0d accept=%b required 0/1", waddr, wr_accept);
        end
        step();
        inc = 1'b0;
        n_cmp++;
        if (wlevel !== 5'd1 || waddr !== 4'd1 || wptr !== 5'b00001) begin
            n_fail++;
            $display("FAIL post_reset_write: got lvl=%0d waddr=%0d wptr=%b required 1/1/00001", wlevel, waddr, wptr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
